md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the execute stage of the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ID/EX register and holds results in architectural HI/LO registers. It runs multi-cycle operations with a busy flag and a stall request for the hazard unit. Its `result` output is one of the data inputs of the execute-stage result-select multiplexer (the slot chosen for MFHI/MFLO).

## Interface
- MULT_CYCLES, 5: busy duration of MULT/MULTU, in cycles (≥1).
- DIV_CYCLES, 10: busy duration of DIV/DIVU, in cycles (≥1).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  request valid this cycle.
- op  in  3  3'b001 MULT, 3'b010 MULTU, 3'b011 DIV, 3'b100 DIVU, 3'b101 MTHI, 3'b110 MTLO; any other value is a no-op.
- A  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- B  in  32  rt operand: multiplier or divisor.
- rd_sel  in  1  1 = HI, 0 = LO, for `result`.
- busy  out  1  operation in flight.
- stall_req  out  1  combinational: busy | (start & op ∈ {001..100}).
- HI  out  32  HI register.
- LO  out  32  LO register.
- result  out  32  combinational: rd_sel ? HI : LO.

## Operation
- States: IDLE and RUN. The state, a countdown counter, and pending_hi/pending_lo registers hold the in-flight operation.
- Reset (reset = 0, asynchronous):
  - State is IDLE, busy = 0, counter = 0, HI = LO = 0, pending registers = 0.
  - An operation in flight is discarded; nothing is written to HI/LO.
- IDLE behaviour on a rising edge with start = 1:
  - MULT: pending = signed(A) × signed(B), 64-bit. HI gets bits 63:32, LO gets bits 31:0. Counter = MULT_CYCLES. Go to RUN.
  - MULTU: the same, with both operands unsigned.
  - DIV: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. Counter = DIV_CYCLES. Go to RUN.
  - DIVU: unsigned quotient and remainder. Counter = DIV_CYCLES. Go to RUN.
  - Divide by zero (B = 0, DIV or DIVU): pending = current {HI, LO}, so HI/LO are unchanged at completion. The full DIV_CYCLES busy period is still spent.
  - MTHI: HI = A at this edge; stay IDLE; busy stays 0.
  - MTLO: LO = A at this edge; stay IDLE; busy stays 0.
  - Other op values: no effect.
- RUN behaviour:
  - The counter decrements each edge.
  - On the edge where the counter goes 1 → 0: HI/LO are loaded from pending, busy falls, and the state returns to IDLE.
  - start is ignored in RUN. The CPU's stall logic guarantees that no MD op issues while busy; the unit still drops any such request.
- result always reflects the current HI/LO registers. There is no bypass of pending values.

## Timing
- Multi-cycle op with start sampled at edge T:
  - busy = 1 from just after edge T until edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new values at edge T+N.
  - busy is 0 after edge T+N.
  - A new start may be accepted at edge T+N.
- stall_req is high in the cycle of T (combinationally from start) and in every busy cycle. It is low in the cycle after completion.
- MTHI/MTLO: HI/LO update at the sampling edge, so `result` shows the new value one cycle later.
- Reset asserted mid-RUN: busy drops asynchronously. After release, the unit is IDLE and accepts start on the first edge.
- Simultaneous start and completion edge: the old op's writeback and the new op's launch both occur at that edge. If the new op is MTHI/MTLO, its write takes precedence for that register.

## Test plan
- Reset, then MULT with A = 0xFFFFFFFE (−2), B = 3 → busy high exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU with A = 0xFFFFFFFF, B = 0xFFFFFFFF → after 5 cycles HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV with A = 0xFFFFFFF9 (−7), B = 2 → busy 10 cycles; LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Then DIVU with A = 7, B = 0 → HI/LO unchanged after 10 busy cycles.
- MTHI with A = 0x12345678, then MTLO with A = 0x9ABCDEF0 on consecutive cycles → busy stays 0. With rd_sel = 1, result = 0x12345678; with rd_sel = 0, result = 0x9ABCDEF0.
- Assert reset at cycle 3 of a DIV → busy = 0 immediately, HI = LO = 0. A MULT with A = 4, B = 5 issued after release gives LO = 20 after 5 cycles.
- Issue a second MULT while busy → it is ignored and HI/LO reflect only the first op. Then issue a start on the completion edge → it is accepted, with stall_req continuous across both ops.

Source files
------------

// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the execute stage.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and keeps the architectural
// HI/LO registers. Multiply and divide results are computed at launch, parked
// in pending registers, and committed to HI/LO when the busy countdown expires.
// This reproduces the pipeline timing of an iterative unit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request valid this cycle
//   op         001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   A, B       rs / rt operands
//   rd_sel     1 selects HI, 0 selects LO on result
//   busy       multi-cycle operation in flight
//   stall_req  busy, or a multi-cycle op being requested right now
//   HI, LO     architectural registers
//   result     rd_sel ? HI : LO (no bypass of pending values)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        hi_nx, lo_nx;
  logic [31:0]        pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
  logic               accept;
  logic               is_md;

  function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Divides magnitudes and restores signs afterwards. The most-negative
  // dividend over -1 thereby yields 0x80000000 rem 0 without a special case.
  // Returns {remainder, quotient}; the caller guarantees b != 0.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31])         r = -r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign busy      = (state == RUN);
  assign is_md     = (op >= OP_MULT) && (op <= OP_DIVU);
  assign stall_req = busy | (start & is_md);
  assign result    = rd_sel ? HI : LO;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = HI;
    lo_nx      = LO;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    accept     = (state == IDLE);

    if (state == RUN) begin
      cnt_nx = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        // Completion edge: commit, and allow a back-to-back launch.
        hi_nx    = pend_hi;
        lo_nx    = pend_lo;
        state_nx = IDLE;
        accept   = 1'b1;
      end
    end

    if (start && accept) begin
      unique case (op)
        OP_MULT: begin
          {pend_hi_nx, pend_lo_nx} = mul_s(A, B);
          cnt_nx   = CNT_W'(MULT_CYCLES);
          state_nx = RUN;
        end
        OP_MULTU: begin
          {pend_hi_nx, pend_lo_nx} = mul_u(A, B);
          cnt_nx   = CNT_W'(MULT_CYCLES);
          state_nx = RUN;
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero keeps HI/LO: park the values HI/LO hold after this edge.
          if (B == 32'd0)
            {pend_hi_nx, pend_lo_nx} = {hi_nx, lo_nx};
          else if (op == OP_DIV)
            {pend_hi_nx, pend_lo_nx} = div_s(A, B);
          else
            {pend_hi_nx, pend_lo_nx} = div_u(A, B);
          cnt_nx   = CNT_W'(DIV_CYCLES);
          state_nx = RUN;
        end
        OP_MTHI: hi_nx = A;
        OP_MTLO: lo_nx = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      HI      <= hi_nx;
      LO      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed steps followed by randomized operations,
// checked against a 64-bit arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        rd_sel;
  logic        busy, stall_req;
  logic [31:0] HI, LO, result;

  logic [31:0] m_hi, m_lo;
  int          passed = 0;
  int          failed = 0;

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .rd_sel(rd_sel), .busy(busy), .stall_req(stall_req),
    .HI(HI), .LO(LO), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: new {HI, LO} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int cycles_of(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MULT_CYCLES;
    if (o == 3'd3 || o == 3'd4) return DIV_CYCLES;
    return 0;
  endfunction

  // Counts edges until busy falls; bounded so a stuck unit cannot hang the run.
  task automatic wait_done(output int n, output bit stall_bad);
    n = 0;
    stall_bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (stall_req !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
    rd_sel = 1'b1; #1;
    chk({tag, "_result_hi"}, result, m_hi);
    rd_sel = 1'b0; #1;
    chk({tag, "_result_lo"}, result, m_lo);
  endtask

  // Issues one op (called #1 after an edge) and runs it to completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          n;
    bit          sb;
    bit          md;
    md = (cycles_of(o) != 0);
    start = 1'b1; op = o; A = a; B = b;
    #1;
    chk("stall_req_issue", 32'(stall_req), 32'(md));
    e = model(o, a, b, m_hi, m_lo);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    if (md) begin
      chk("busy_launch", 32'(busy), 32'd1);
      chk("hi_no_bypass", HI, m_hi);
      chk("lo_no_bypass", LO, m_lo);
      wait_done(n, sb);
      chk("busy_cycles", 32'(n), 32'(cycles_of(o)));
      chk("stall_while_busy", 32'(sb), 32'd0);
      chk("stall_after_done", 32'(stall_req), 32'd0);
    end else begin
      chk("busy_nonmd", 32'(busy), 32'd0);
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
    check_regs("regs");
  endtask

  initial begin
    logic [63:0] e1, e2;
    int          n;
    bit          sb;
    bit          stall_bad;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi_const", HI, 32'hFFFFFFFF);
    chk("mult_lo_const", LO, 32'hFFFFFFFA);

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi_const", HI, 32'hFFFFFFFE);
    chk("multu_lo_const", LO, 32'h00000001);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_lo_const", LO, 32'hFFFFFFFD);
    chk("div_hi_const", HI, 32'hFFFFFFFF);

    run_op(3'd4, 32'd7, 32'd0);
    chk("divu0_lo_const", LO, 32'hFFFFFFFD);
    chk("divu0_hi_const", HI, 32'hFFFFFFFF);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_const", LO, 32'h80000000);
    chk("div_ovf_hi_const", HI, 32'h00000000);

    run_op(3'd5, 32'h12345678, 32'd0);
    run_op(3'd6, 32'h9ABCDEF0, 32'd0);
    rd_sel = 1'b1; #1;
    chk("mthi_result_const", result, 32'h12345678);
    rd_sel = 1'b0; #1;
    chk("mtlo_result_const", result, 32'h9ABCDEF0);

    // Reset in the third cycle of a DIV.
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_stall", 32'(stall_req), 32'd0);
    chk("midreset_hi", HI, 32'd0);
    chk("midreset_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(3'd1, 32'd4, 32'd5);
    chk("post_reset_lo_const", LO, 32'd20);

    // A second MULT while busy is dropped.
    e1 = model(3'd1, 32'd3, 32'hFFFFFFF9, m_hi, m_lo);
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'hFFFFFFF9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; A = 32'd1000; B = 32'd1000;
    #1;
    chk("busy_issue_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    wait_done(n, sb);
    chk("ignored_remaining_cycles", 32'(n), 32'(MULT_CYCLES - 2));
    m_hi = e1[63:32]; m_lo = e1[31:0];
    check_regs("ignored");

    // Launch on the completion edge; stall_req must not drop in between.
    e1 = model(3'd2, 32'h00010000, 32'h00030000, m_hi, m_lo);
    e2 = model(3'd3, 32'hFFFFFF9C, 32'd7, e1[63:32], e1[31:0]);
    stall_bad = 1'b0;
    start = 1'b1; op = 3'd2; A = 32'h00010000; B = 32'h00030000;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < MULT_CYCLES - 1; i++) begin
      if (stall_req !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("b2b_busy_before", 32'(busy), 32'd1);
    start = 1'b1; op = 3'd3; A = 32'hFFFFFF9C; B = 32'd7;
    #1;
    if (stall_req !== 1'b1) stall_bad = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("b2b_busy_after", 32'(busy), 32'd1);
    chk("b2b_first_hi", HI, e1[63:32]);
    chk("b2b_first_lo", LO, e1[31:0]);
    wait_done(n, sb);
    chk("b2b_second_cycles", 32'(n), 32'(DIV_CYCLES));
    chk("b2b_stall_continuous", 32'(stall_bad | sb), 32'd0);
    m_hi = e2[63:32]; m_lo = e2[31:0];
    check_regs("b2b_second");

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op(ro, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
